// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: FSM encoding and
// default fairness/lock limits.
package data_ram_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int DEF_MAX_WAIT = 8;
    localparam int DEF_LOCK_MAX = 16;

endpackage

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter in front of the data RAM: core LSU (m0) has priority,
// DMA/debug (m1) gets an anti-starvation boost and bounded locked bursts.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [3:0] WAIT_TOP = 4'(MAX_WAIT);
    localparam logic [4:0] LOCK_TOP = 5'(LOCK_MAX);

    arb_state_e  state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [4:0]  lock_q, lock_d;
    logic [4:0]  lock_inc;
    logic        force_q, force_d;
    logic        rv0_q, rv1_q;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;

    // force_q gives m0 the first slot after a forced lock release
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (m0_req && m1_req) begin
                        if (!force_q && wait_q == WAIT_TOP) m1_gnt = 1'b1;
                        else                                m0_gnt = 1'b1;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
                ARB_LOCKED: m1_gnt = m1_req;
            endcase
        end
    end

    always_comb begin
        ram_ce    = m0_gnt | m1_gnt;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_sel   = '0;
        ram_wdata = '0;
        if (m0_gnt) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_sel   = m0_sel;
            ram_wdata = m0_wdata;
        end else if (m1_gnt) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_sel   = m1_sel;
            ram_wdata = m1_wdata;
        end
    end

    assign lock_inc = lock_q + 5'd1;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        lock_d  = lock_q;
        force_d = 1'b0;
        if (m1_gnt)                         wait_d = '0;
        else if (m1_req && wait_q != WAIT_TOP) wait_d = wait_q + 4'd1;
        unique case (state_q)
            ARB_IDLE: begin
                if (m1_gnt && m1_lock) begin
                    state_d = ARB_LOCKED;
                    lock_d  = 5'd1;
                end
            end
            ARB_LOCKED: begin
                if (!m1_req) begin
                    state_d = ARB_IDLE;
                end else if (lock_inc == LOCK_TOP) begin
                    state_d = ARB_IDLE;
                    force_d = 1'b1;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_inc;
                    if (!m1_lock) state_d = ARB_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rd0_d = rd0_q;
        rd1_d = rd1_q;
        if (m0_gnt) rd0_d = m0_we ? 32'd0 : ram_rdata;
        if (m1_gnt) rd1_d = m1_we ? 32'd0 : ram_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            wait_q  <= '0;
            lock_q  <= '0;
            force_q <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            lock_q  <= lock_d;
            force_q <= force_d;
            rv0_q   <= m0_gnt;
            rv1_q   <= m1_gnt;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_rdata  = rd0_q;
    assign m1_rdata  = rd1_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_data_ram_arbiter;

    localparam int MAXW = 8;
    localparam int LOCKM = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_sel;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_sel;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;

    logic [31:0] mem [0:255];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    data_ram_arbiter #(.MAX_WAIT(MAXW), .LOCK_MAX(LOCKM)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_sel(m0_sel), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_sel(m1_sel), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_sel(ram_sel), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    assign ram_rdata = mem[ram_addr[9:2]];

    always @(posedge clk) begin
        if (ram_ce && ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_sel = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_sel = 0; m1_wdata = 0;
        m1_lock = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_single_read();
        do_reset();
        mem[4] = 32'hDEADBEEF;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_sel = 4'hF;
        #2;
        total_cnt++;
        if ({m0_gnt, m1_gnt, ram_ce, ram_we} !== 4'b1010)
            $display("FAIL read_gnt got %b want 1010", {m0_gnt, m1_gnt, ram_ce, ram_we});
        else pass_cnt++;
        total_cnt++;
        if (ram_addr !== 32'h10) $display("FAIL read_addr got %h want 10", ram_addr);
        else pass_cnt++;
        @(negedge clk);
        m0_req = 0;
        #2;
        total_cnt++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF)
            $display("FAIL read_rvalid got %b/%h want 1/deadbeef", m0_rvalid, m0_rdata);
        else pass_cnt++;
        total_cnt++;
        if (ram_ce !== 1'b0 || ram_addr !== 32'h0)
            $display("FAIL idle_ram got ce=%b addr=%h want 0/0", ram_ce, ram_addr);
        else pass_cnt++;
        @(negedge clk);
        #2;
        total_cnt++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF)
            $display("FAIL rdata_hold got %b/%h want 0/deadbeef", m0_rvalid, m0_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        m0_req = 1; m1_req = 1;
        #2;
        total_cnt++;
        if ({m0_gnt, m1_gnt, ram_ce} !== 3'b000)
            $display("FAIL reset_gnt got %b want 000", {m0_gnt, m1_gnt, ram_ce});
        else pass_cnt++;
        @(negedge clk);
        #2;
        total_cnt++;
        if (m0_rvalid !== 0 || m1_rvalid !== 0 || m0_rdata !== 0 || m1_rdata !== 0)
            $display("FAIL reset_regs got %b %b %h %h want 0", m0_rvalid, m1_rvalid,
                     m0_rdata, m1_rdata);
        else pass_cnt++;
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_starvation();
        int first;
        int m0n;
        do_reset();
        m0_req = 1; m0_sel = 4'hF; m0_addr = 32'h4;
        m1_req = 1; m1_sel = 4'hF; m1_addr = 32'h8;
        for (int pass = 0; pass < 2; pass++) begin
            first = -1;
            m0n = 0;
            for (int c = 0; c < 20 && first < 0; c++) begin
                #2;
                if (m1_gnt) first = c;
                else if (m0_gnt) m0n++;
                @(negedge clk);
            end
            total_cnt++;
            if (first != MAXW || m0n != MAXW)
                $display("FAIL starve_m1 pass%0d got cycle %0d m0n %0d want %0d",
                         pass, first, m0n, MAXW);
            else pass_cnt++;
        end
        idle_inputs();
    endtask

    task automatic test_lock_burst();
        logic [1:0] g [0:4];
        do_reset();
        m1_req = 1; m1_lock = 1; m1_sel = 4'hF; m1_addr = 32'h20;
        for (int c = 0; c < 5; c++) begin
            #2;
            g[c] = {m0_gnt, m1_gnt};
            @(negedge clk);
            m0_req = 1; m0_sel = 4'hF;
            m1_lock = (c < 2);
            m1_req = (c < 3);
        end
        total_cnt++;
        if ({g[0], g[1], g[2], g[3], g[4]} !== 10'b01_01_01_01_10)
            $display("FAIL lock_burst got %b want 0101010110",
                     {g[0], g[1], g[2], g[3], g[4]});
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_forced_release();
        int n1;
        int g16;
        int m0cyc;
        int resume;
        do_reset();
        n1 = 0; g16 = -1; m0cyc = -1; resume = -1;
        m1_req = 1; m1_lock = 1; m1_sel = 4'hF;
        for (int c = 0; c < 40 && n1 < 20; c++) begin
            #2;
            if (m0_gnt && m0cyc < 0) m0cyc = c;
            if (m1_gnt) begin
                n1++;
                if (n1 == LOCKM) g16 = c;
                if (m0cyc >= 0 && resume < 0) resume = c;
            end
            @(negedge clk);
            m0_req = (m0cyc < 0);
            m1_req = (n1 < 20);
        end
        total_cnt++;
        if (g16 != LOCKM - 1) $display("FAIL force_g16 got %0d want %0d", g16, LOCKM - 1);
        else pass_cnt++;
        total_cnt++;
        if (m0cyc != LOCKM) $display("FAIL force_m0 got %0d want %0d", m0cyc, LOCKM);
        else pass_cnt++;
        total_cnt++;
        if (resume != LOCKM + 1 || n1 != 20)
            $display("FAIL force_resume got %0d n1 %0d want %0d/20", resume, n1, LOCKM + 1);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_write_m1();
        do_reset();
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;
        m1_req = 1; m1_we = 0; m1_addr = 32'h10; m1_sel = 4'hF;
        @(negedge clk);
        m1_we = 1; m1_addr = 32'h20; m1_sel = 4'b0010; m1_wdata = 32'h0000AB00;
        #2;
        total_cnt++;
        if ({m1_gnt, ram_we, ram_sel} !== 6'b11_0010 || ram_wdata !== 32'h0000AB00)
            $display("FAIL wr_port got %b %h want 110010 0000ab00",
                     {m1_gnt, ram_we, ram_sel}, ram_wdata);
        else pass_cnt++;
        total_cnt++;
        if (m1_rdata !== 32'hDEADBEEF)
            $display("FAIL m1_read got %h want deadbeef", m1_rdata);
        else pass_cnt++;
        @(negedge clk);
        m1_req = 0;
        #2;
        total_cnt++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h0)
            $display("FAIL wr_rvalid got %b/%h want 1/0", m1_rvalid, m1_rdata);
        else pass_cnt++;
        total_cnt++;
        if (mem[8] !== 32'h1122AB44) $display("FAIL wr_lane got %h want 1122ab44", mem[8]);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        m1_req = 1; m1_lock = 1; m1_sel = 4'hF;
        #2;
        total_cnt++;
        if (m1_gnt !== 1'b1) $display("FAIL rml_lock got %b want 1", m1_gnt);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 0;
        m0_req = 1; m0_sel = 4'hF;
        #2;
        total_cnt++;
        if ({m0_gnt, m1_gnt, ram_ce} !== 3'b000)
            $display("FAIL rml_inreset got %b want 000", {m0_gnt, m1_gnt, ram_ce});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1;
        #2;
        total_cnt++;
        if ({m1_rvalid, m0_gnt, m1_gnt} !== 3'b010)
            $display("FAIL rml_after got %b want 010", {m1_rvalid, m0_gnt, m1_gnt});
        else pass_cnt++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        int locked, waitc, lockc, forced;
        logic p0, p1, g0, g1;
        logic ev0, ev1;
        logic [31:0] ed0, ed1, ea;
        do_reset();
        locked = 0; waitc = 0; lockc = 0; forced = 0;
        ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
        p0 = 0; p1 = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1; m0_we = 1'($urandom); m0_sel = 4'($urandom);
                m0_addr = {22'd0, 8'($urandom), 2'b00}; m0_wdata = $urandom;
            end
            if (!p1 && $urandom_range(0, 7) != 0) begin
                p1 = 1; m1_we = 1'($urandom); m1_sel = 4'($urandom);
                m1_addr = {22'd0, 8'($urandom), 2'b00}; m1_wdata = $urandom;
                m1_lock = ($urandom_range(0, 15) != 0);
            end
            m0_req = p0;
            m1_req = p1;
            #2;
            g0 = 0; g1 = 0;
            if (rst_n) begin
                if (locked != 0) g1 = p1;
                else if (p0 && p1) begin
                    g1 = (forced == 0 && waitc == MAXW);
                    g0 = !g1;
                end else begin
                    g0 = p0; g1 = p1;
                end
            end
            ea = g0 ? m0_addr : (g1 ? m1_addr : 32'd0);
            total_cnt++;
            if ({m0_gnt, m1_gnt, ram_ce} !== {g0, g1, g0 | g1} || ram_addr !== ea)
                $display("FAIL rnd_gnt c%0d got %b %h want %b %h", c,
                         {m0_gnt, m1_gnt, ram_ce}, ram_addr, {g0, g1, g0 | g1}, ea);
            else pass_cnt++;
            total_cnt++;
            if ({m0_rvalid, m1_rvalid} !== {ev0, ev1} || m0_rdata !== ed0 || m1_rdata !== ed1)
                $display("FAIL rnd_resp c%0d got %b %h %h want %b %h %h", c,
                         {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, {ev0, ev1}, ed0, ed1);
            else pass_cnt++;
            if (!rst_n) begin
                locked = 0; waitc = 0; lockc = 0; forced = 0;
                ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
            end else begin
                ev0 = g0; ev1 = g1;
                if (g0) ed0 = m0_we ? 32'd0 : mem[m0_addr[9:2]];
                if (g1) ed1 = m1_we ? 32'd0 : mem[m1_addr[9:2]];
                if (g1) waitc = 0;
                else if (p1 && waitc < MAXW) waitc++;
                forced = 0;
                if (locked == 0) begin
                    if (g1 && m1_lock) begin locked = 1; lockc = 1; end
                end else if (!p1) begin
                    locked = 0;
                end else begin
                    lockc++;
                    if (lockc == LOCKM) begin locked = 0; forced = 1; lockc = 0; end
                    else if (!m1_lock) locked = 0;
                end
            end
            if (g0) p0 = 0;
            if (g1) p1 = 0;
            @(negedge clk);
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_single_read();
        test_reset();
        test_starvation();
        test_lock_burst();
        test_forced_release();
        test_write_m1();
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
